// File: rtl/fifo_reader_if.sv
// fifo_reader_if: groups the command/status, FIFO read-port and output-stream
// signals of fifo_reader.
//   Command/status : startEn, burstLen (to reader); busy, done, wordCount (from reader)
//   FIFO read port : empty, readData (to reader); readEn (from reader)
//   Output stream  : outReady (to reader); outValid, outData (from reader)
// The master modport is the reader's view. The slave modport is the view of
// the FIFO, the downstream sink and the command source combined.
interface fifo_reader_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 8
);
  logic                 startEn;
  logic [LenWidth-1:0]  burstLen;
  logic                 busy;
  logic                 done;
  logic                 empty;
  logic [DataWidth-1:0] readData;
  logic                 readEn;
  logic                 outValid;
  logic                 outReady;
  logic [DataWidth-1:0] outData;
  logic [LenWidth-1:0]  wordCount;

  modport master (
    input  startEn,
    input  burstLen,
    input  empty,
    input  readData,
    input  outReady,
    output busy,
    output done,
    output readEn,
    output outValid,
    output outData,
    output wordCount
  );

  modport slave (
    output startEn,
    output burstLen,
    output empty,
    output readData,
    output outReady,
    input  busy,
    input  done,
    input  readEn,
    input  outValid,
    input  outData,
    input  wordCount
  );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: read-side consumer for a first-word-fall-through synchronous FIFO.
// It accepts a burst command of burstLen words, pops exactly that many words,
// and forwards them in order through a 2-entry registered buffer onto a
// valid/ready stream. A one-cycle done pulse follows the last accepted word.
// Ports:
//   clk  - single clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - fifo_reader_if.master (command/status, FIFO read port, output stream)
module fifo_reader #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 8
) (
  input logic           clk,
  input logic           rst,
  fifo_reader_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StFlush
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [LenWidth-1:0]  r_remaining;
  logic [LenWidth-1:0]  r_burst_len;
  logic [LenWidth-1:0]  r_word_count;
  logic [DataWidth-1:0] r_buf0;       // head entry, drives outData
  logic [DataWidth-1:0] r_buf1;       // tail entry, only valid when count==2
  logic [1:0]           r_buf_count;
  logic                 r_done;

  logic                 w_start;
  logic                 w_push;
  logic                 w_pop;

  // A start is only honoured in IDLE; anything else is dropped, not queued.
  assign w_start = (r_state == StIdle) && bus.startEn;

  // Pop decision uses registered state plus empty only, so outReady has no
  // combinational path to readEn. rst gates it so the FIFO is never popped in
  // a reset cycle, whatever state the register held beforehand.
  assign w_push = (r_state == StBurst) && !bus.empty && (r_remaining != '0) &&
                  (r_buf_count != 2'd2) && !rst;

  assign w_pop  = (r_buf_count != 2'd0) && bus.outReady;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (bus.startEn) begin
          w_state_next = (bus.burstLen != '0) ? StBurst : StFlush;
        end
      end
      StBurst: begin
        // Last word of the burst is being popped at this edge.
        if (w_push && (r_remaining == LenWidth'(1))) begin
          w_state_next = StFlush;
        end
      end
      StFlush: begin
        if (r_buf_count == 2'd0) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // done is registered: it is high in the first IDLE cycle after FLUSH drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == StFlush) && (r_buf_count == 2'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Burst counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
      r_burst_len <= '0;
    end else if (w_start) begin
      r_remaining <= bus.burstLen;
      r_burst_len <= bus.burstLen;
    end else if (w_push) begin
      r_remaining <= r_remaining - LenWidth'(1);
    end
  end

  // Saturating at the captured length keeps a max-length burst from wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (w_start) begin
      r_word_count <= '0;
    end else if (w_pop && (r_word_count != r_burst_len)) begin
      r_word_count <= r_word_count + LenWidth'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry in-order buffer. Entries shift toward the head on a pop so the
  // head is always r_buf0 and outData needs no read mux.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_buf_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_buf_count == 2'd0) begin
            r_buf0 <= bus.readData;
          end else begin
            r_buf1 <= bus.readData;
          end
          r_buf_count <= r_buf_count + 2'd1;
        end
        2'b01: begin
          r_buf0      <= r_buf1;
          r_buf_count <= r_buf_count - 2'd1;
        end
        2'b11: begin
          // Head leaves and the new word lands behind whatever remains.
          if (r_buf_count == 2'd1) begin
            r_buf0 <= bus.readData;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.readData;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.readEn    = w_push;
  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = r_done;
  assign bus.outValid  = (r_buf_count != 2'd0);
  assign bus.outData   = r_buf0;
  assign bus.wordCount = r_word_count;

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: self-checking bench for fifo_reader. The FIFO is a queue in
// the bench (first-word-fall-through), and the expected output stream is the
// sequence of words pushed into that FIFO, in push order, truncated to burstLen.
module tb_fifo_reader;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_reader_if #(.DataWidth(DW), .LenWidth(LW)) bus ();

  fifo_reader #(.DataWidth(DW), .LenWidth(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] fifo_q[$];  // words currently held in the modelled FIFO
  logic [DW-1:0] ref_q[$];   // every word pushed since the last clear, in order

  int n_pops, n_acc, n_done, n_busy, n_cyc;
  int first_acc, last_acc, done_cyc;
  bit s_busy, s_rd, s_valid;
  bit stall_prev = 1'b0;
  logic [DW-1:0] stall_data;

  task automatic drive_fifo();
    bus.empty    = (fifo_q.size() == 0);
    bus.readData = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    ref_q.push_back(w);
  endtask

  task automatic clear_all();
    fifo_q.delete();
    ref_q.delete();
  endtask

  // One clock: drive FIFO flags, sample everything on the falling edge, then
  // advance past the rising edge.
  task automatic cycle();
    logic [DW-1:0] tmp;
    drive_fifo();
    @(negedge clk);
    n_cyc++;
    s_busy  = bus.busy;
    s_rd    = bus.readEn;
    s_valid = bus.outValid;
    if (bus.busy === 1'b1) n_busy++;
    if (bus.readEn === 1'b1) begin
      n_checks++;
      if (bus.empty !== 1'b0) begin
        n_errors++;
        $display("FAIL readEn_when_empty: empty=%b readEn=1, required no pop while empty",
                 bus.empty);
      end
      if (fifo_q.size() != 0) tmp = fifo_q.pop_front();
      n_pops++;
    end
    if (stall_prev && !rst) begin
      n_checks++;
      if (bus.outValid !== 1'b1 || bus.outData !== stall_data) begin
        n_errors++;
        $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                 bus.outValid, bus.outData, stall_data);
      end
    end
    if (bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
      n_checks++;
      if (n_acc >= ref_q.size()) begin
        n_errors++;
        $display("FAIL extra_word: got data=%h, required no word (index %0d)", bus.outData,
                 n_acc);
      end else if (bus.outData !== ref_q[n_acc]) begin
        n_errors++;
        $display("FAIL out_word[%0d]: got %h, required %h", n_acc, bus.outData, ref_q[n_acc]);
      end
      if (first_acc < 0) first_acc = n_cyc;
      last_acc = n_cyc;
      n_acc++;
    end
    stall_prev = (bus.outValid === 1'b1) && (bus.outReady !== 1'b1) && !rst;
    stall_data = bus.outData;
    if (bus.done === 1'b1) begin
      n_done++;
      done_cyc = n_cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_burst(input int len);
    n_pops = 0; n_acc = 0; n_done = 0; n_busy = 0;
    first_acc = -1; last_acc = -1; done_cyc = -1;
    bus.startEn  = 1'b1;
    bus.burstLen = LW'(len);
    cycle();
    bus.startEn  = 1'b0;
    bus.burstLen = LW'($urandom);
  endtask

  // Runs until done (bounded), then two more cycles so a repeated pulse shows.
  task automatic wait_done(input int budget, input bit rand_ready, input string name);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      if (rand_ready) bus.outReady = ($urandom_range(0, 3) != 0);
      cycle();
      k++;
    end
    n_checks++;
    if (n_done == 0) begin
      n_errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, budget);
    end
    bus.outReady = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    clear_all();
    push_word(32'hDEAD_BEEF);
    rst = 1'b1;
    bus.outReady = 1'b1;
    cycle();
    n_checks++;
    if (s_rd !== 1'b0) begin
      n_errors++; $display("FAIL reset_readEn: got %b, required 0", s_rd);
    end
    cycle();
    rst = 1'b0;
    cycle();
    n_checks++;
    if (s_rd !== 1'b0) begin
      n_errors++; $display("FAIL post_reset_readEn: got %b, required 0", s_rd);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.outValid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got busy=%b done=%b valid=%b, required 0 0 0", bus.busy,
               bus.done, bus.outValid);
    end
    n_checks++;
    if (bus.outData !== '0 || bus.wordCount !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got outData=%h wordCount=%0d, required 0 0", bus.outData,
               bus.wordCount);
    end
    clear_all();
  endtask

  task automatic test_basic();
    clear_all();
    push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
    bus.outReady = 1'b1;
    new_burst(3);
    cycle();
    n_checks++;
    if (s_busy !== 1'b1 || s_rd !== 1'b1 || s_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_latency: got busy=%b readEn=%b valid=%b, required 1 1 0", s_busy,
               s_rd, s_valid);
    end
    wait_done(20, 1'b0, "basic");
    n_checks++;
    if (n_pops != 3 || n_acc != 3) begin
      n_errors++;
      $display("FAIL basic_count: got pops=%0d accepts=%0d, required 3 3", n_pops, n_acc);
    end
    n_checks++;
    if (last_acc - first_acc != 2) begin
      n_errors++;
      $display("FAIL basic_back_to_back: got span=%0d, required 2", last_acc - first_acc);
    end
    n_checks++;
    if (n_done != 1 || bus.wordCount !== LW'(3)) begin
      n_errors++;
      $display("FAIL basic_done: got done=%0d wordCount=%0d, required 1 3", n_done,
               bus.wordCount);
    end
    drive_fifo();
    n_checks++;
    if (fifo_q.size() != 1 || bus.empty !== 1'b0 || fifo_q[0] !== 32'h44) begin
      n_errors++;
      $display("FAIL basic_leftover: got size=%0d empty=%b, required 1 word 44, empty=0",
               fifo_q.size(), bus.empty);
    end
    clear_all();
  endtask

  task automatic test_zero_len();
    clear_all();
    push_word(32'h55);
    bus.outReady = 1'b1;
    new_burst(0);
    wait_done(10, 1'b0, "zero");
    n_checks++;
    if (n_busy != 1 || n_done != 1 || n_pops != 0) begin
      n_errors++;
      $display("FAIL zero_len: got busy_cycles=%0d done=%0d pops=%0d, required 1 1 0",
               n_busy, n_done, n_pops);
    end
    clear_all();
  endtask

  task automatic test_empty_wait();
    clear_all();
    bus.outReady = 1'b1;
    new_burst(4);
    repeat (5) cycle();
    n_checks++;
    if (n_pops != 0 || s_busy !== 1'b1 || bus.wordCount !== '0) begin
      n_errors++;
      $display("FAIL empty_wait: got pops=%0d busy=%b wordCount=%0d, required 0 1 0", n_pops,
               s_busy, bus.wordCount);
    end
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    wait_done(30, 1'b0, "empty");
    n_checks++;
    if (n_acc != 4 || n_pops != 4 || n_done != 1 || bus.wordCount !== LW'(4)) begin
      n_errors++;
      $display("FAIL empty_resume: got acc=%0d pops=%0d done=%0d wc=%0d, required 4 4 1 4",
               n_acc, n_pops, n_done, bus.wordCount);
    end
    n_checks++;
    if (done_cyc <= last_acc) begin
      n_errors++;
      $display("FAIL empty_done_order: got done cycle %0d last accept %0d, required later",
               done_cyc, last_acc);
    end
    clear_all();
  endtask

  task automatic test_backpressure();
    clear_all();
    for (int i = 0; i < 5; i++) push_word($urandom);
    bus.outReady = 1'b0;
    new_burst(4);
    repeat (6) cycle();
    n_checks++;
    if (n_pops != 2 || s_rd !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_pops: got pops=%0d readEn=%b, required 2 0", n_pops, s_rd);
    end
    n_checks++;
    if (bus.outValid !== 1'b1 || bus.outData !== ref_q[0]) begin
      n_errors++;
      $display("FAIL bp_head: got valid=%b data=%h, required 1 %h", bus.outValid, bus.outData,
               ref_q[0]);
    end
    bus.outReady = 1'b1;
    wait_done(30, 1'b0, "bp");
    n_checks++;
    if (n_acc != 4 || n_pops != 4 || fifo_q.size() != 1 || n_done != 1) begin
      n_errors++;
      $display("FAIL bp_release: got acc=%0d pops=%0d left=%0d done=%0d, required 4 4 1 1",
               n_acc, n_pops, fifo_q.size(), n_done);
    end
    clear_all();
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_all();
    for (int i = 0; i < 6; i++) push_word($urandom);
    bus.outReady = 1'b0;
    new_burst(6);
    while (n_pops < 2 && k < 10) begin
      cycle();
      k++;
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.outValid !== 1'b0 || bus.wordCount !== '0) begin
      n_errors++;
      $display("FAIL rst_mid: got busy=%b valid=%b wc=%0d, required 0 0 0", bus.busy,
               bus.outValid, bus.wordCount);
    end
    repeat (4) cycle();
    n_checks++;
    if (n_done != 0 || n_pops != 2) begin
      n_errors++;
      $display("FAIL rst_mid_quiet: got done=%0d pops=%0d, required 0 2", n_done, n_pops);
    end
    clear_all();
    push_word(32'h0BAD_CAFE);
    bus.outReady = 1'b1;
    new_burst(1);
    wait_done(20, 1'b0, "rst_restart");
    n_checks++;
    if (n_acc != 1 || n_done != 1 || bus.wordCount !== LW'(1)) begin
      n_errors++;
      $display("FAIL rst_restart: got acc=%0d done=%0d wc=%0d, required 1 1 1", n_acc, n_done,
               bus.wordCount);
    end
    clear_all();
  endtask

  task automatic test_restart_ignored();
    clear_all();
    for (int i = 0; i < 8; i++) push_word($urandom);
    bus.outReady = 1'b1;
    new_burst(3);
    bus.startEn  = 1'b1;
    bus.burstLen = LW'(7);
    cycle();
    cycle();
    bus.startEn  = 1'b0;
    wait_done(30, 1'b0, "restart");
    n_checks++;
    if (n_pops != 3 || n_acc != 3 || n_done != 1 || bus.wordCount !== LW'(3)) begin
      n_errors++;
      $display("FAIL restart_ignored: got pops=%0d acc=%0d done=%0d wc=%0d, required 3 3 1 3",
               n_pops, n_acc, n_done, bus.wordCount);
    end
    clear_all();
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      int len = $urandom_range(1, 24);
      int k = 0;
      clear_all();
      for (int i = 0; i < $urandom_range(0, len); i++) push_word($urandom);
      bus.outReady = 1'b1;
      new_burst(len);
      while (n_done == 0 && k < 400) begin
        if (ref_q.size() < len + 3 && $urandom_range(0, 2) == 0) push_word($urandom);
        bus.outReady = ($urandom_range(0, 3) != 0);
        cycle();
        k++;
      end
      bus.outReady = 1'b1;
      cycle();
      cycle();
      n_checks++;
      if (n_done != 1 || n_acc != len || n_pops != len || bus.wordCount !== LW'(len)) begin
        n_errors++;
        $display("FAIL random[%0d]: got done=%0d acc=%0d pops=%0d wc=%0d, required 1 %0d %0d %0d",
                 b, n_done, n_acc, n_pops, bus.wordCount, len, len, len);
      end
    end
    clear_all();
  endtask

  task automatic test_max_len();
    clear_all();
    for (int i = 0; i < 260; i++) push_word($urandom);
    bus.outReady = 1'b1;
    new_burst(255);
    wait_done(2000, 1'b1, "max");
    n_checks++;
    if (n_acc != 255 || n_pops != 255 || bus.wordCount !== LW'(255) || fifo_q.size() != 5 ||
        n_done != 1) begin
      n_errors++;
      $display("FAIL max_len: got acc=%0d pops=%0d wc=%0d left=%0d done=%0d, required 255 255 255 5 1",
               n_acc, n_pops, bus.wordCount, fifo_q.size(), n_done);
    end
    clear_all();
  endtask

  initial begin
    rst          = 1'b1;
    bus.startEn  = 1'b0;
    bus.burstLen = '0;
    bus.outReady = 1'b0;
    bus.empty    = 1'b1;
    bus.readData = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_empty_wait();
    test_backpressure();
    test_reset_mid();
    test_restart_ignored();
    test_random();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run by time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
